// File: rtl/cache_pkg.sv
// Shared types and constants for the cache-to-RAM line protocol.
// Holds the default geometry used by the RAM responder and the cache controller bench.
package cache_pkg;

    typedef enum logic [1:0] {
        RAM_IDLE = 2'd0,
        RAM_BUSY = 2'd1,
        RAM_RESP = 2'd2
    } ram_state_t;

    localparam int DEF_ADDR_W      = 32;
    localparam int DEF_WORD_W      = 32;
    localparam int DEF_LINE_WORDS  = 4;
    localparam int DEF_DEPTH_LINES = 256;
    localparam int DEF_LATENCY     = 4;

    localparam int LINE_W = DEF_WORD_W * DEF_LINE_WORDS;
    localparam int OFF_W  = $clog2(LINE_W / 8);
    localparam int IDX_W  = $clog2(DEF_DEPTH_LINES);

    // Width of a down-counter that must hold latency-1 (at least one bit).
    function automatic int lat_cnt_w(input int latency);
        return (latency > 1) ? $clog2(latency) : 1;
    endfunction

endpackage

// File: rtl/ram_line_array.sv
// Line-wide single-port backing array, one block RAM per word lane.
// Read data is registered and held until the next read; it is cleared by rst.
module ram_line_array #(
    parameter int WORD_W      = 32,
    parameter int LINE_WORDS  = 4,
    parameter int DEPTH_LINES = 256,
    parameter int IDX_W       = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         we,
    input  logic                         re,
    input  logic [IDX_W-1:0]             idx,
    input  logic [WORD_W*LINE_WORDS-1:0] wdata,
    output logic [WORD_W*LINE_WORDS-1:0] rdata
);

    genvar gi;
    generate
        for (gi = 0; gi < LINE_WORDS; gi++) begin : g_lane
            logic [WORD_W-1:0] mem [DEPTH_LINES];
            logic [WORD_W-1:0] rdata_reg;

            always_ff @(posedge clk) begin
                if (we) begin
                    mem[idx] <= wdata[gi*WORD_W +: WORD_W];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    rdata_reg <= '0;
                end else if (re) begin
                    rdata_reg <= mem[idx];
                end
            end

            assign rdata[gi*WORD_W +: WORD_W] = rdata_reg;
        end
    endgenerate

endmodule

// File: rtl/ram_line_responder.sv
// Memory-side responder for line write-back/refill requests with fixed access latency.
// Optional access counters are built when RAM_ACCESS_CNT_EN is defined.
module ram_line_responder
    import cache_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int WORD_W      = DEF_WORD_W,
    parameter int LINE_WORDS  = DEF_LINE_WORDS,
    parameter int DEPTH_LINES = DEF_DEPTH_LINES,
    parameter int LATENCY     = DEF_LATENCY
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable_cache_to_ram,
    input  logic                         write_cache_to_ram,
    input  logic [ADDR_W-1:0]            addr_cache_to_ram,
    input  logic [WORD_W*LINE_WORDS-1:0] line_cache_to_ram,
    output logic                         response_ram_to_cache,
    output logic [WORD_W*LINE_WORDS-1:0] line_ram_to_cache,
    output logic                         ram_busy
`ifdef RAM_ACCESS_CNT_EN
    ,
    output logic [31:0]                  ram_rd_cnt,
    output logic [31:0]                  ram_wr_cnt
`endif
);

    localparam int LINE_BITS = WORD_W * LINE_WORDS;
    localparam int OFF_BITS  = $clog2(LINE_BITS / 8);
    localparam int IDX_BITS  = $clog2(DEPTH_LINES);
    localparam int CNT_W     = lat_cnt_w(LATENCY);

    ram_state_t           state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg;
    logic                 wr_reg;
    logic [IDX_BITS-1:0]  idx_reg;
    logic [LINE_BITS-1:0] wdata_reg;
    logic                 accept;
    logic                 access;
    logic                 arr_we;
    logic                 arr_re;
    logic                 addr_unused;

    // Only the index field of the address selects a line; the rest wraps away.
    assign addr_unused = ^addr_cache_to_ram;

    assign accept = (state_reg == RAM_IDLE) && enable_cache_to_ram;
    assign access = (state_reg == RAM_BUSY) && (cnt_reg == '0);
    assign arr_we = access && wr_reg && !rst;
    assign arr_re = access && !wr_reg && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= RAM_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RAM_IDLE: if (enable_cache_to_ram) state_next = RAM_BUSY;
            RAM_BUSY: if (cnt_reg == '0)       state_next = RAM_RESP;
            RAM_RESP:                          state_next = RAM_IDLE;
            default:                           state_next = RAM_IDLE;
        endcase
    end

    always_comb begin
        ram_busy              = (state_reg != RAM_IDLE);
        response_ram_to_cache = (state_reg == RAM_RESP);
    end

    // Request fields are captured only at accept; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg   <= '0;
            wr_reg    <= 1'b0;
            idx_reg   <= '0;
            wdata_reg <= '0;
        end else if (accept) begin
            cnt_reg   <= CNT_W'(LATENCY - 1);
            wr_reg    <= write_cache_to_ram;
            idx_reg   <= addr_cache_to_ram[OFF_BITS +: IDX_BITS];
            wdata_reg <= line_cache_to_ram;
        end else if ((state_reg == RAM_BUSY) && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    ram_line_array #(
        .WORD_W      (WORD_W),
        .LINE_WORDS  (LINE_WORDS),
        .DEPTH_LINES (DEPTH_LINES),
        .IDX_W       (IDX_BITS)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (arr_we),
        .re    (arr_re),
        .idx   (idx_reg),
        .wdata (wdata_reg),
        .rdata (line_ram_to_cache)
    );

`ifdef RAM_ACCESS_CNT_EN
    // Counters step on entry to RESP and saturate at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_rd_cnt <= '0;
            ram_wr_cnt <= '0;
        end else if (access) begin
            if (wr_reg && (ram_wr_cnt != '1)) begin
                ram_wr_cnt <= ram_wr_cnt + 32'd1;
            end
            if (!wr_reg && (ram_rd_cnt != '1)) begin
                ram_rd_cnt <= ram_rd_cnt + 32'd1;
            end
        end
    end
`else
    // Access counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_ram_line_responder.sv
// Directed plus randomized bench for ram_line_responder against a line-array reference model.
// Counter checks are included when RAM_ACCESS_CNT_EN is defined.
module tb_ram_line_responder;

    localparam int LAT   = 4;
    localparam int LINEB = 128;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic             write;
    logic [31:0]      addr;
    logic [LINEB-1:0] line_in;
    logic             response;
    logic [LINEB-1:0] line_out;
    logic             busy;
`ifdef RAM_ACCESS_CNT_EN
    logic [31:0]      rd_cnt;
    logic [31:0]      wr_cnt;
`endif

    always #5 clk = ~clk;

    ram_line_responder #(
        .ADDR_W      (32),
        .WORD_W      (32),
        .LINE_WORDS  (4),
        .DEPTH_LINES (256),
        .LATENCY     (LAT)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .enable_cache_to_ram   (enable),
        .write_cache_to_ram    (write),
        .addr_cache_to_ram     (addr),
        .line_cache_to_ram     (line_in),
        .response_ram_to_cache (response),
        .line_ram_to_cache     (line_out),
        .ram_busy              (busy)
`ifdef RAM_ACCESS_CNT_EN
        ,
        .ram_rd_cnt            (rd_cnt),
        .ram_wr_cnt            (wr_cnt)
`endif
    );

    // Reference model: line contents by index, plus the line last returned by a read.
    logic [LINEB-1:0] mem_m [256];
    bit               vld_m [256];
    logic [LINEB-1:0] last_rd;
    bit               last_known;
    int               rd_n;
    int               wr_n;
    int               n_tests;
    int               n_fail;

    function automatic int idx_of(input logic [31:0] a);
        return int'((a / 32'd16) % 32'd256);
    endfunction

    function automatic logic [LINEB-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [LINEB-1:0] obs, input logic [LINEB-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge. from_resp: DUT is in RESP with enable still held.
    task automatic transact(input bit wr, input logic [31:0] a, input logic [LINEB-1:0] d,
                            input bit from_resp, input int drop_after, input bit keep_en);
        int n;
        int ix;
        enable  = 1'b1;
        write   = wr;
        addr    = a;
        line_in = d;
        if (from_resp) begin
            @(posedge clk);
            @(negedge clk);
            chk("turn_resp", response, 0);
            chk("turn_busy", busy, 0);
        end
        @(posedge clk);
        @(negedge clk);
        chk("accept_busy", busy, 1);
        write   = 1'($urandom);
        addr    = $urandom;
        line_in = rand_line();
        n = 0;
        while (n < 50) begin
            if (n == drop_after) enable = 1'b0;
            @(posedge clk);
            n++;
            @(negedge clk);
            if (response) break;
        end
        chk("latency", n, LAT);
        chk("resp_busy", busy, 1);
        ix = idx_of(a);
        if (wr) begin
            mem_m[ix] = d;
            vld_m[ix] = 1'b1;
            wr_n++;
        end else begin
            rd_n++;
            last_known = vld_m[ix];
            last_rd    = mem_m[ix];
        end
        if (last_known) chk(wr ? "held_line" : "rd_line", line_out, last_rd);
        $display("[TB] %s addr=%h idx=%0d lat=%0d line_out=%h", wr ? "WR" : "RD", a, ix, n, line_out);
        write = 1'b0;
        if (!keep_en) begin
            enable = 1'b0;
            @(posedge clk);
            @(negedge clk);
            chk("pulse_end", response, 0);
            chk("idle_busy", busy, 0);
        end
    endtask

    task automatic chk_counts();
`ifdef RAM_ACCESS_CNT_EN
        chk("rd_cnt", rd_cnt, rd_n);
        chk("wr_cnt", wr_cnt, wr_n);
`endif
    endtask

    initial begin
        logic [LINEB-1:0] dcba;
        logic [LINEB-1:0] aaaa;
        logic [LINEB-1:0] dwrap;
        bit               prev_keep;
        bit               keep;
        bit               wr;
        int               drop;
        logic [31:0]      a;

        n_tests = 0; n_fail = 0; rd_n = 0; wr_n = 0;
        last_rd = '0; last_known = 1'b1;
        foreach (vld_m[i]) vld_m[i] = 1'b0;
        rst = 1'b1; enable = 1'b0; write = 1'b0; addr = '0; line_in = '0;
        dcba  = 128'h0000000D_0000000C_0000000B_0000000A;
        aaaa  = {4{32'hAAAA_AAAA}};
        dwrap = 128'h1234_5678_9ABC_DEF0_0F1E_2D3C_4B5A_6978;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_resp", response, 0);
        chk("rst_busy", busy, 0);
        chk("rst_line", line_out, 0);
        chk_counts();
        rst = 1'b0;

        // Preload line 0x10 then refill it.
        transact(1'b1, 32'h0000_0100, dcba, 1'b0, 99, 1'b0);
        transact(1'b0, 32'h0000_0100, 128'h0, 1'b0, 99, 1'b0);

        // Write-back then refill back to back with enable held.
        transact(1'b1, 32'h0000_0040, aaaa, 1'b0, 99, 1'b1);
        transact(1'b0, 32'h0000_0040, 128'h0, 1'b1, 99, 1'b0);

        // Index wrap and offset bits ignored.
        transact(1'b1, 32'h0000_1000, dwrap, 1'b0, 99, 1'b0);
        transact(1'b0, 32'h0000_0000, 128'h0, 1'b0, 99, 1'b1);
        transact(1'b0, 32'h0000_000C, 128'h0, 1'b1, 99, 1'b0);

        // Enable dropped two cycles after accept; no further responses.
        transact(1'b0, 32'h0000_0100, 128'h0, 1'b0, 2, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("no_resp", response, 0);
        end
        chk_counts();

        // Reset during a write: write discarded, outputs cleared.
        enable = 1'b1; write = 1'b1; addr = 32'h0000_0100; line_in = rand_line();
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1; enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rstbusy_resp", response, 0);
        chk("rstbusy_busy", busy, 0);
        chk("rstbusy_line", line_out, 0);
        rd_n = 0; wr_n = 0; last_rd = '0; last_known = 1'b1;
        chk_counts();
        rst = 1'b0;
        @(negedge clk);
        transact(1'b0, 32'h0000_0100, 128'h0, 1'b0, 99, 1'b0);

        // Randomized traffic over a small set of lines to force collisions.
        prev_keep = 1'b0;
        for (int t = 0; t < 40; t++) begin
            wr   = 1'($urandom);
            a    = ($urandom & 32'hFFFF_F00F) | (($urandom % 8) << 4);
            drop = (($urandom % 3) == 0) ? int'($urandom % LAT) : 99;
            keep = (t == 39) ? 1'b0 : 1'($urandom);
            if (keep) drop = 99;
            transact(wr, a, rand_line(), prev_keep, drop, keep);
            prev_keep = keep;
        end
        chk_counts();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
